// File: rtl/seq_shifter_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_shifter_if
// Description : Request/result bundle between a shift requester and
//               seq_shifter.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_shifter_if #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(2*WIDTH)
);
    logic                 start;
    logic [1:0]           mode;
    logic [SHW-1:0]       amt;
    logic [WIDTH-1:0]     a;
    logic [2*WIDTH-1:0]   res;
    logic                 busy;
    logic                 done;

    modport master (
        output start, mode, amt, a,
        input  res, busy, done
    );

    modport slave (
        input  start, mode, amt, a,
        output res, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/seq_shifter.sv
`default_nettype none
// ============================================================================
// Module      : seq_shifter
// Description : Bit-serial shifter; one 1-bit shift/rotate per clock on a
//               double-width result register.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_shifter #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(2*WIDTH)
) (
    input  logic          clk,
    input  logic          reset,
    seq_shifter_if.slave  bus
);

    localparam int             c_RW  = 2 * WIDTH;
    localparam logic [SHW-1:0] c_ONE = {{(SHW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            r_state;
    logic [c_RW-1:0]   r_res;
    logic [SHW-1:0]    r_count;
    logic [1:0]        r_mode;
    logic              r_busy;
    logic              r_done;

    logic [c_RW-1:0]   w_shifted;
    logic [c_RW-1:0]   w_load;

    // Arithmetic-right mode pre-extends the sign so the upper half behaves
    // like a signed 2*WIDTH operand from the first shift on.
    always_comb begin
        w_load = {{WIDTH{1'b0}}, bus.a};
        if (bus.mode == 2'b10) begin
            w_load = {{WIDTH{bus.a[WIDTH-1]}}, bus.a};
        end
    end

    always_comb begin
        w_shifted = r_res;
        case (r_mode)
            2'b00:   w_shifted = {r_res[c_RW-2:0], 1'b0};
            2'b01:   w_shifted = {1'b0, r_res[c_RW-1:1]};
            2'b10:   w_shifted = {r_res[c_RW-1], r_res[c_RW-1:1]};
            default: w_shifted = {r_res[c_RW-2:0], r_res[c_RW-1]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_res   <= '0;
            r_count <= '0;
            r_mode  <= 2'b00;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        r_mode <= bus.mode;
                        r_res  <= w_load;
                        if (bus.amt == '0) begin
                            r_state <= DONE;
                            r_count <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= SHIFT;
                            r_count <= bus.amt;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                        end
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                end
                SHIFT: begin
                    // Start is deliberately not looked at here.
                    r_res   <= w_shifted;
                    r_count <= r_count - c_ONE;
                    if (r_count == c_ONE) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.res  = r_res;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_seq_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_shifter
// Description : Directed self-checking bench for seq_shifter (WIDTH=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_shifter;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    seq_shifter_if #(.WIDTH(16)) bus ();

    seq_shifter #(.WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for one accept edge, then scrambles the inputs so
    // any late sampling of mode/amt/a would corrupt the result.
    task automatic op_issue(input logic [1:0] m, input logic [15:0] aa, input logic [4:0] n);
        bus.start = 1'b1;
        bus.mode  = m;
        bus.a     = aa;
        bus.amt   = n;
        step();
        bus.start = 1'b0;
        bus.mode  = ~m;
        bus.a     = ~aa;
        bus.amt   = ~n;
    endtask

    // Called just after the accept edge; returns in the done cycle.
    task automatic op_check(input string tag, input int n,
                            input logic [31:0] exp_load, input logic [31:0] exp_res);
        chk({tag, "_load"}, 64'(bus.res), 64'(exp_load));
        for (int i = 0; i < n; i++) begin
            chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
            chk({tag, "_nodone"}, 64'(bus.done), 64'd0);
            step();
        end
        chk({tag, "_done"}, 64'(bus.done), 64'd1);
        chk({tag, "_idlebusy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_res"}, 64'(bus.res), 64'(exp_res));
    endtask

    task automatic idle_check(input string tag, input logic [31:0] exp_res);
        step();
        chk({tag, "_done_clr"}, 64'(bus.done), 64'd0);
        chk({tag, "_busy_clr"}, 64'(bus.busy), 64'd0);
        chk({tag, "_hold"}, 64'(bus.res), 64'(exp_res));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.mode    = 2'b00;
        bus.a       = 16'h0000;
        bus.amt     = 5'd0;
        step();
        step();
        reset = 1'b0;
        chk("rst_res", 64'(bus.res), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);

        // Logical left by WIDTH moves a into the upper half.
        op_issue(2'b00, 16'hABCD, 5'd16);
        op_check("lsl16", 16, 32'h0000ABCD, 32'hABCD0000);
        idle_check("lsl16", 32'hABCD0000);
        step();
        chk("lsl16_hold2", 64'(bus.res), 64'h00000000ABCD0000);

        op_issue(2'b10, 16'h8001, 5'd4);
        op_check("asr4", 4, 32'hFFFF8001, 32'hFFFFF800);
        idle_check("asr4", 32'hFFFFF800);

        op_issue(2'b11, 16'h8001, 5'd31);
        op_check("rol31", 31, 32'h00008001, 32'h80004000);
        idle_check("rol31", 32'h80004000);

        op_issue(2'b01, 16'h1234, 5'd0);
        op_check("lsr0", 0, 32'h00001234, 32'h00001234);
        idle_check("lsr0", 32'h00001234);

        op_issue(2'b01, 16'h1234, 5'd4);
        op_check("lsr4", 4, 32'h00001234, 32'h00000123);
        idle_check("lsr4", 32'h00000123);

        op_issue(2'b00, 16'h8001, 5'd3);
        op_check("lsl3", 3, 32'h00008001, 32'h00040008);
        idle_check("lsl3", 32'h00040008);

        // A second start mid-shift must be ignored entirely.
        op_issue(2'b00, 16'h00FF, 5'd8);
        chk("ign_load", 64'(bus.res), 64'h00000000000000FF);
        for (int i = 0; i < 8; i++) begin
            chk("ign_busy", 64'(bus.busy), 64'd1);
            if (i == 3) begin
                bus.start = 1'b1;
                bus.mode  = 2'b01;
                bus.a     = 16'hFFFF;
                bus.amt   = 5'd1;
            end
            step();
            bus.start = 1'b0;
        end
        chk("ign_done", 64'(bus.done), 64'd1);
        chk("ign_res", 64'(bus.res), 64'h000000000000FF00);
        idle_check("ign", 32'h0000FF00);

        // Reset in the middle of a shift.
        op_issue(2'b00, 16'h0003, 5'd10);
        step();
        step();
        step();
        chk("rmid_busy_pre", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rmid_res", 64'(bus.res), 64'd0);
        chk("rmid_busy", 64'(bus.busy), 64'd0);
        chk("rmid_done", 64'(bus.done), 64'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("rmid_nodone", 64'(bus.done), 64'd0);
        end
        op_issue(2'b01, 16'hF000, 5'd12);
        op_check("rmid_fresh", 12, 32'h0000F000, 32'h0000000F);

        // Back-to-back: new request presented while in DONE.
        idle_check("rmid_fresh", 32'h0000000F);
        op_issue(2'b00, 16'h0001, 5'd2);
        op_check("b2b1", 2, 32'h00000001, 32'h00000004);
        op_issue(2'b11, 16'hF000, 5'd4);
        chk("b2b2_busy_rise", 64'(bus.busy), 64'd1);
        op_check("b2b2", 4, 32'h0000F000, 32'h000F0000);
        idle_check("b2b2", 32'h000F0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the input operand width in bits (legal: power of two, 4..64).
REQ-002 The block SHALL have parameter SHW, default $clog2(2*WIDTH), giving the shift-amount width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request pulse; sampled only when the request can be accepted.
REQ-006 mode  input  2  00 logical left, 01 logical right, 10 arithmetic right, 11 rotate left.
REQ-007 amt  input  SHW  shift amount, 0..2*WIDTH-1.
REQ-008 a  input  WIDTH  operand.
REQ-009 res  output  2*WIDTH  registered shift result.
REQ-010 busy  output  1  high while shifting.
REQ-011 done  output  1  one-cycle completion pulse.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-013 Start is accepted only in IDLE or DONE; start in SHIFT SHALL be ignored with no effect on res, count or mode.
REQ-014 On the accept edge, mode and amt SHALL be captured, and res SHALL load {WIDTH zeros, a} for modes 00/01/11, or {WIDTH copies of a[WIDTH-1], a} for mode 10.
REQ-015 Accept edge, amt=0: next state SHALL be DONE; otherwise next state SHALL be SHIFT with count=amt.
REQ-016 Each SHIFT-state edge SHALL perform exactly one 1-bit operation on the full 2*WIDTH res register and decrement count.
REQ-017 Mode 00 SHALL shift left, inserting 0 at bit 0.
REQ-018 Mode 01 SHALL shift right, inserting 0 at the MSB.
REQ-019 Mode 10 SHALL shift right, replicating res[2*WIDTH-1].
REQ-020 Mode 11 SHALL rotate left, moving res[2*WIDTH-1] into bit 0.
REQ-021 The edge on which count goes from 1 to 0 SHALL perform the last shift and move the FSM to DONE.
REQ-022 Latency: if start is accepted on edge k with amt=N, done SHALL be high for the cycle following edge k+N, and res SHALL then hold the final value.
REQ-023 busy SHALL be high exactly in SHIFT; done SHALL be high exactly in DONE.
REQ-024 In DONE without start, the FSM SHALL return to IDLE on the next edge.
REQ-025 In DONE with start, the new request SHALL be accepted (back-to-back).
REQ-026 res SHALL hold its value in IDLE and DONE until the next accept or reset.
REQ-027 amt=WIDTH with mode 00 SHALL yield a in the upper half and zeros in the lower half.
REQ-028 Mode, amt and a SHALL only be sampled on the accept edge; changes during SHIFT SHALL not affect the operation in progress.

Reset
REQ-029 reset high at an edge SHALL force state IDLE, res=0, count=0, busy=0 and done=0, overriding start and any operation in progress.
REQ-030 After reset deasserts, the first start SHALL be accepted normally.

Verification (WIDTH=16)
REQ-031 mode=00, a=16'hABCD, amt=16 -> res=32'hABCD0000; busy for 16 cycles; done one cycle after edge k+16.
REQ-032 mode=10, a=16'h8001, amt=4 -> load 32'hFFFF8001, final res=32'hFFFFF800 after 4 shifts.
REQ-033 mode=11, a=16'h8001, amt=31 -> res=32'h80004000; mode=01, a=16'h1234, amt=0 -> res=32'h00001234, done in the cycle after the accept edge, busy never high.
REQ-034 Start pulse with a different a/amt during SHIFT -> ignored; original result and timing unchanged.
REQ-035 reset asserted mid-SHIFT -> next edge res=0, busy=0, done=0; no done pulse; a fresh start then completes correctly.
REQ-036 Back-to-back: start held during DONE -> second operation accepted that edge, busy rises next cycle, both results correct.
